// File: rtl/tank_pkg.sv
`default_nettype none
// ============================================================================
// Module : tank_pkg
// Brief  : Shared types and playfield limits for the tank bullet logic.
// Rev    : 1.0  initial release
// ============================================================================
package tank_pkg;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    typedef enum logic {
        SLOT_IDLE   = 1'b0,
        SLOT_FLYING = 1'b1
    } slot_state_t;

    localparam logic [9:0] c_X_MIN = 10'd1;
    localparam logic [9:0] c_X_MAX = 10'd639;
    localparam logic [9:0] c_Y_MIN = 10'd1;
    localparam logic [9:0] c_Y_MAX = 10'd479;

endpackage
`default_nettype wire

// File: rtl/bullet_pool_if.sv
`default_nettype none
// ============================================================================
// Module : bullet_pool_if
// Brief  : Tank-side inputs and renderer-side outputs of the bullet pool.
// Rev    : 1.0  initial release
// ============================================================================
interface bullet_pool_if #(
    parameter int NUM_BULLETS = 4
);
    logic [1:0]               direction;
    logic [7:0]               keycode;
    logic [9:0]               BallX;
    logic [9:0]               BallY;
    logic [9:0]               BallS;
    logic [NUM_BULLETS-1:0]   barrier_hit;
    logic [10*NUM_BULLETS-1:0] BulletX;
    logic [10*NUM_BULLETS-1:0] BulletY;
    logic [9:0]               BulletS;
    logic [NUM_BULLETS-1:0]   bullet_on;
    logic                     fire_event;
    logic [3:0]               free_count;

    modport master (
        output direction, keycode, BallX, BallY, BallS, barrier_hit,
        input  BulletX, BulletY, BulletS, bullet_on, fire_event, free_count
    );

    modport slave (
        input  direction, keycode, BallX, BallY, BallS, barrier_hit,
        output BulletX, BulletY, BulletS, bullet_on, fire_event, free_count
    );
endinterface
`default_nettype wire

// File: rtl/bullet_slot.sv
`default_nettype none
// ============================================================================
// Module : bullet_slot
// Brief  : One projectile: idle/flying FSM, position, latched heading, kill test.
// Rev    : 1.0  initial release
// ============================================================================
module bullet_slot
    import tank_pkg::*;
#(
    parameter logic [9:0] STEP        = 10'd12,
    parameter logic [9:0] BULLET_SIZE = 10'd4,
    parameter logic [9:0] X_MIN       = c_X_MIN,
    parameter logic [9:0] X_MAX       = c_X_MAX,
    parameter logic [9:0] Y_MIN       = c_Y_MIN,
    parameter logic [9:0] Y_MAX       = c_Y_MAX
) (
    input  wire        clk,
    input  wire        rst_n,
    input  wire        i_launch,
    input  wire  [1:0] i_dir,
    input  wire  [9:0] i_ball_x,
    input  wire  [9:0] i_ball_y,
    input  wire        i_barrier_hit,
    output logic       o_on,
    output logic [9:0] o_x,
    output logic [9:0] o_y
);

    slot_state_t r_state, w_state_nx;
    dir_t        r_dir,   w_dir_nx;
    logic [9:0]  r_x,     w_x_nx;
    logic [9:0]  r_y,     w_y_nx;
    logic        w_edge;
    logic        w_kill;

    // 11-bit compares so neither the +SIZE nor the -SIZE side can wrap
    assign w_edge = ({1'b0, r_y} + {1'b0, BULLET_SIZE} >= {1'b0, Y_MAX}) ||
                    ({1'b0, r_y} <= {1'b0, Y_MIN} + {1'b0, BULLET_SIZE}) ||
                    ({1'b0, r_x} + {1'b0, BULLET_SIZE} >= {1'b0, X_MAX}) ||
                    ({1'b0, r_x} <= {1'b0, X_MIN} + {1'b0, BULLET_SIZE});
    assign w_kill = (r_state == SLOT_FLYING) && (w_edge || i_barrier_hit);

    always_comb begin
        w_state_nx = r_state;
        w_dir_nx   = r_dir;
        w_x_nx     = r_x;
        w_y_nx     = r_y;
        case (r_state)
            SLOT_IDLE: begin
                w_x_nx = i_ball_x;
                w_y_nx = i_ball_y;
                if (i_launch) begin
                    w_state_nx = SLOT_FLYING;
                    w_dir_nx   = dir_t'(i_dir);
                end
            end
            SLOT_FLYING: begin
                if (w_kill) begin
                    w_state_nx = SLOT_IDLE;
                    w_x_nx     = i_ball_x;
                    w_y_nx     = i_ball_y;
                end else begin
                    case (r_dir)
                        DIR_LEFT:  w_x_nx = r_x - STEP;
                        DIR_RIGHT: w_x_nx = r_x + STEP;
                        DIR_DOWN:  w_y_nx = r_y + STEP;
                        DIR_UP:    w_y_nx = r_y - STEP;
                        default:   w_x_nx = r_x;
                    endcase
                end
            end
            default: w_state_nx = SLOT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SLOT_IDLE;
            r_dir   <= DIR_LEFT;
            r_x     <= i_ball_x;
            r_y     <= i_ball_y;
        end else begin
            r_state <= w_state_nx;
            r_dir   <= w_dir_nx;
            r_x     <= w_x_nx;
            r_y     <= w_y_nx;
        end
    end

    assign o_on = (r_state == SLOT_FLYING);
    assign o_x  = r_x;
    assign o_y  = r_y;

endmodule
`default_nettype wire

// File: rtl/bullet_pool.sv
`default_nettype none
// ============================================================================
// Module : bullet_pool
// Brief  : NUM_BULLETS-slot bullet generator with edge-triggered fire and cooldown.
// Rev    : 1.0  initial release
// ============================================================================
module bullet_pool
    import tank_pkg::*;
#(
    parameter int         NUM_BULLETS = 4,
    parameter logic [7:0] FIRE_KEY    = 8'd88,
    parameter logic [9:0] STEP        = 10'd12,
    parameter logic [9:0] BULLET_SIZE = 10'd4,
    parameter logic [9:0] X_MIN       = c_X_MIN,
    parameter logic [9:0] X_MAX       = c_X_MAX,
    parameter logic [9:0] Y_MIN       = c_Y_MIN,
    parameter logic [9:0] Y_MAX       = c_Y_MAX,
    parameter logic [3:0] COOLDOWN    = 4'd8
) (
    input  wire         frame_clk,
    input  wire         Reset,
    bullet_pool_if.slave bus
);

    logic                   r_armed;
    logic [3:0]             r_cooldown;
    logic                   r_fire_event;
    logic [NUM_BULLETS-1:0] w_on;
    logic [NUM_BULLETS-1:0] w_launch;
    logic                   w_fire_key;
    logic                   w_fire_ok;
    logic                   w_any_idle;
    logic [3:0]             w_free;
    logic                   w_unused_balls;

    // tank size is carried on the bus for parity with the tank object only
    assign w_unused_balls = ^bus.BallS;

    assign w_fire_key = (bus.keycode == FIRE_KEY);
    assign w_fire_ok  = w_fire_key && r_armed && (r_cooldown == 4'd0);
    assign w_any_idle = ~&w_on;

    always_comb begin
        logic found;
        found    = 1'b0;
        w_launch = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!w_on[i] && !found) begin
                w_launch[i] = w_fire_ok;
                found       = 1'b1;
            end
        end
    end

    always_comb begin
        w_free = 4'd0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            w_free = w_free + {3'd0, ~w_on[i]};
        end
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            r_armed      <= 1'b1;
            r_cooldown   <= 4'd0;
            r_fire_event <= 1'b0;
        end else begin
            r_armed      <= !w_fire_key;
            r_fire_event <= w_fire_ok && w_any_idle;
            if (w_fire_ok && w_any_idle) begin
                r_cooldown <= COOLDOWN;
            end else if (r_cooldown != 4'd0) begin
                r_cooldown <= r_cooldown - 4'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BULLETS; gi++) begin : g_slot
            bullet_slot #(
                .STEP        (STEP),
                .BULLET_SIZE (BULLET_SIZE),
                .X_MIN       (X_MIN),
                .X_MAX       (X_MAX),
                .Y_MIN       (Y_MIN),
                .Y_MAX       (Y_MAX)
            ) u_slot (
                .clk           (frame_clk),
                .rst_n         (Reset),
                .i_launch      (w_launch[gi]),
                .i_dir         (bus.direction),
                .i_ball_x      (bus.BallX),
                .i_ball_y      (bus.BallY),
                .i_barrier_hit (bus.barrier_hit[gi]),
                .o_on          (w_on[gi]),
                .o_x           (bus.BulletX[10*gi +: 10]),
                .o_y           (bus.BulletY[10*gi +: 10])
            );
        end
    endgenerate

    assign bus.bullet_on  = w_on;
    assign bus.fire_event = r_fire_event;
    assign bus.free_count = w_free;
    assign bus.BulletS    = BULLET_SIZE;

endmodule
`default_nettype wire
